// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF input synchronizer, mid-bit sampling FSM
// and a small first-word-fall-through receive FIFO with valid/ready.
module uart_rx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_BAUD  = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_in,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BIT_CYCLES  = CLK_FREQ / UART_BAUD;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);
    localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic          rx_meta_q;
    logic          rx_s_q;
    logic          rx_prev_q;
    logic [1:0]    fill_q;
    logic          armed_q;
    logic          fall;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          push;
    logic          ferr;

    logic          frame_err_q;
    logic          overrun_q;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [NW-1:0] count_q;
    logic          full;
    logic          pop;
    logic          wr_en;

    // Synchronize the line; arm edge detection only after a real high is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            fill_q    <= 2'b00;
            armed_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx_in;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            fill_q    <= {fill_q[0], 1'b1};
            armed_q   <= armed_q | (fill_q[1] & rx_s_q);
        end
    end

    assign fall = armed_q & rx_prev_q & ~rx_s_q;

    // Frame FSM next state: start validation, data shift, stop check.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        push    = 1'b0;
        ferr    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame FSM registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    assign full  = (count_q == FULL_CNT);
    assign pop   = rx_valid & rx_ready;
    assign wr_en = push & (~full | pop);

    // FIFO pointers, occupancy and the two one-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q     <= count_q + NW'(wr_en) - NW'(pop);
            frame_err_q <= ferr;
            overrun_q   <= push & full & ~pop;
        end
    end

    // FIFO storage; contents need no reset since rx_data is gated by valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    assign rx_valid   = (count_q != '0);
    assign rx_data    = rx_valid ? mem[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16 clocks per bit.
// A negedge monitor records pops, flag pulses and busy cycles.
module tb_uart_rx;

    localparam int BIT  = 16;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    logic [2:0] fifo_count;

    int errors = 0;
    int checks = 0;

    logic [7:0] got [$];
    int fe_cnt, ov_cnt, both_cnt, busy_cyc, max_cnt;

    logic [7:0] msg [13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                             8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21,
                             8'h0A};

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ   (1_600_000),
        .UART_BAUD  (100_000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && rx_ready) got.push_back(rx_data);
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (frame_err && overrun) both_cnt++;
            if (busy) busy_cyc++;
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        got.delete();
        fe_cnt   = 0;
        ov_cnt   = 0;
        both_cnt = 0;
        busy_cyc = 0;
        max_cnt  = 0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        rx_in = 1'b0;
        cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            cyc(BIT);
        end
        rx_in = stop;
        cyc(BIT);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        rx_in    = 1'b0;
        rx_ready = 1'b1;
        cyc(3);
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx_data: got %h want 00", rx_data);
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rx_valid: got %b want 0", rx_valid);
        end
        checks++;
        if (frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got fe=%b ov=%b want 0 0",
                     frame_err, overrun);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        checks++;
        if (fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", fifo_count);
        end
        rst = 1'b0;
        clr();
        cyc(3 * BIT);
        checks++;
        if (busy_cyc !== 0) begin
            errors++;
            $display("FAIL low_at_release: got busy_cyc=%0d want 0", busy_cyc);
        end
        rx_in = 1'b1;
        cyc(BIT);
    endtask

    task automatic test_single();
        rx_ready = 1'b1;
        clr();
        send_byte(8'h48, 1'b1);
        cyc(BIT);
        checks++;
        if (got.size() !== 1 || got[0] !== 8'h48) begin
            errors++;
            $display("FAIL single_byte: got n=%0d first=%h want n=1 48",
                     got.size(), (got.size() > 0) ? got[0] : 8'hxx);
        end
        checks++;
        if (max_cnt !== 1 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL single_count: got max=%0d now=%0d want 1 0",
                     max_cnt, fifo_count);
        end
        checks++;
        if (fe_cnt !== 0 || ov_cnt !== 0) begin
            errors++;
            $display("FAIL single_flags: got fe=%0d ov=%0d want 0 0",
                     fe_cnt, ov_cnt);
        end
    endtask

    task automatic test_stream();
        rx_ready = 1'b1;
        clr();
        for (int i = 0; i < 13; i++) send_byte(msg[i], 1'b1);
        cyc(BIT);
        checks++;
        if (got.size() !== 13) begin
            errors++;
            $display("FAIL stream_len: got %0d want 13", got.size());
        end
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== msg[i]) begin
                errors++;
                $display("FAIL stream_byte%0d: got %h want %h", i,
                         (i < got.size()) ? got[i] : 8'hxx, msg[i]);
            end
        end
        checks++;
        if (fe_cnt !== 0 || ov_cnt !== 0) begin
            errors++;
            $display("FAIL stream_flags: got fe=%0d ov=%0d want 0 0",
                     fe_cnt, ov_cnt);
        end
    endtask

    task automatic test_glitch();
        rx_ready = 1'b1;
        clr();
        rx_in = 1'b0;
        cyc(4);
        rx_in = 1'b1;
        cyc(3 * BIT);
        checks++;
        if (busy_cyc !== HALF || busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy: got cyc=%0d now=%b want %0d 0",
                     busy_cyc, busy, HALF);
        end
        checks++;
        if (got.size() !== 0 || fe_cnt !== 0 || ov_cnt !== 0) begin
            errors++;
            $display("FAIL glitch_quiet: got n=%0d fe=%0d ov=%0d want 0 0 0",
                     got.size(), fe_cnt, ov_cnt);
        end
    endtask

    task automatic test_frame();
        rx_ready = 1'b1;
        clr();
        send_byte(8'h55, 1'b0);
        cyc(200);
        checks++;
        if (fe_cnt !== 1 || got.size() !== 0) begin
            errors++;
            $display("FAIL frame_err_pulse: got fe=%0d n=%0d want 1 0",
                     fe_cnt, got.size());
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_break_hold: got busy=%b want 1", busy);
        end
        rx_in = 1'b1;
        cyc(4);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_break_exit: got busy=%b want 0", busy);
        end
        send_byte(8'hA5, 1'b1);
        cyc(BIT);
        checks++;
        if (got.size() !== 1 || got[0] !== 8'hA5) begin
            errors++;
            $display("FAIL frame_recover: got n=%0d first=%h want n=1 a5",
                     got.size(), (got.size() > 0) ? got[0] : 8'hxx);
        end
        checks++;
        if (fe_cnt !== 1 || ov_cnt !== 0 || both_cnt !== 0) begin
            errors++;
            $display("FAIL frame_flags: got fe=%0d ov=%0d both=%0d want 1 0 0",
                     fe_cnt, ov_cnt, both_cnt);
        end
    endtask

    task automatic test_overrun();
        rx_ready = 1'b0;
        clr();
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        cyc(BIT);
        checks++;
        if (fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL ovr_count: got %0d want 4", fifo_count);
        end
        checks++;
        if (ov_cnt !== 1 || fe_cnt !== 0) begin
            errors++;
            $display("FAIL ovr_pulse: got ov=%0d fe=%0d want 1 0",
                     ov_cnt, fe_cnt);
        end
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h01) begin
            errors++;
            $display("FAIL ovr_head: got v=%b d=%h want 1 01",
                     rx_valid, rx_data);
        end
        rx_ready = 1'b1;
        cyc(8);
        checks++;
        if (got.size() !== 4) begin
            errors++;
            $display("FAIL ovr_pops: got %0d want 4", got.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== 8'(i + 1)) begin
                errors++;
                $display("FAIL ovr_byte%0d: got %h want %h", i,
                         (i < got.size()) ? got[i] : 8'hxx, 8'(i + 1));
            end
        end
        checks++;
        if (fifo_count !== 3'd0 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_drain: got n=%0d v=%b want 0 0",
                     fifo_count, rx_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        d = 8'h33;
        rx_ready = 1'b0;
        clr();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        cyc(BIT);
        checks++;
        if (fifo_count !== 3'd2) begin
            errors++;
            $display("FAIL rmid_queued: got %0d want 2", fifo_count);
        end
        rx_in = 1'b0;
        cyc(BIT);
        for (int i = 0; i < 3; i++) begin
            rx_in = d[i];
            cyc(BIT);
        end
        rx_in = d[3];
        cyc(BIT / 2);
        rst = 1'b1;
        #1;
        checks++;
        if (rx_valid !== 1'b0 || fifo_count !== 3'd0 || rx_data !== 8'h00) begin
            errors++;
            $display("FAIL rmid_fifo: got v=%b n=%0d d=%h want 0 0 00",
                     rx_valid, fifo_count, rx_data);
        end
        checks++;
        if (busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL rmid_state: got busy=%b fe=%b ov=%b want 0 0 0",
                     busy, frame_err, overrun);
        end
        rx_in = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(2 * BIT);
        rx_ready = 1'b1;
        clr();
        send_byte(8'h3C, 1'b1);
        cyc(BIT);
        checks++;
        if (got.size() !== 1 || got[0] !== 8'h3C) begin
            errors++;
            $display("FAIL rmid_next: got n=%0d first=%h want n=1 3c",
                     got.size(), (got.size() > 0) ? got[0] : 8'hxx);
        end
        checks++;
        if (fe_cnt !== 0 || ov_cnt !== 0) begin
            errors++;
            $display("FAIL rmid_flags: got fe=%0d ov=%0d want 0 0",
                     fe_cnt, ov_cnt);
        end
    endtask

    initial begin
        clr();
        test_reset();
        test_single();
        test_stream();
        test_glitch();
        test_frame();
        test_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

8N1 UART receiver for the SoC peripheral bus side of `uart_rx`. It synchronizes the asynchronous serial line, validates the start bit at mid-bit, and samples eight data bits LSB-first plus the stop bit. Received bytes go into a small first-word-fall-through FIFO with a valid/ready output for the bus-facing UART register block. It is the receive-direction counterpart of the existing transmit path.

## Interface
- `CLK_FREQ`, 50_000_000, core clock frequency in Hz.
- `UART_BAUD`, 115200, line baud rate.
- `FIFO_DEPTH`, 4, receive FIFO entries; must be a power of 2, ≥2.
- Derived: `BIT_CYCLES = CLK_FREQ / UART_BAUD` (integer truncation; 434 at defaults); `HALF_CYCLES = BIT_CYCLES / 2` (217).

Ports:
- `clk`  in  1  core clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx_in`  in  1  raw serial line; idle high; asynchronous to `clk`.
- `rx_data`  out  8  FIFO head byte; valid only while `rx_valid`=1.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer accepts the head; a pop occurs when `rx_valid & rx_ready`.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overrun`  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
- `busy`  out  1  high whenever the FSM is not IDLE.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
- Input synchronizer: 2-FF synchronizer on `rx_in`, reset to 1, giving `rx_s`. A third FF `rx_prev` enables falling-edge detection.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: `rx_prev`=1 and `rx_s`=0 → START, with the cycle counter cleared to 0.
- START: counter increments each cycle. At count `HALF_CYCLES-1`, sample `rx_s`:
  - 1 → IDLE (glitch rejected, no flag);
  - 0 → DATA, with counter = 0 and bit index = 0.
- DATA: at count `BIT_CYCLES-1`, sample `rx_s` into shift bit[index] (LSB first) and clear the counter. After index 7 → STOP.
- STOP: at count `BIT_CYCLES-1`, sample `rx_s`:
  - 1 → push the byte and go to IDLE;
  - 0 → pulse `frame_err`, discard the byte, go to BREAK.
- BREAK: wait until `rx_s`=1, then IDLE. No start detection happens while the line stays low.
- Start detection is edge-based. A line that is low at reset release is ignored until it has been seen high.
- FIFO:
  - FWFT; `rx_data` = head entry.
  - A push while full with no simultaneous pop drops the new byte and pulses `overrun`; existing contents are unchanged.
  - A push and a pop in the same cycle while full are both accepted, and the count stays at FIFO_DEPTH.
  - A push and a pop in the same cycle while empty: the push is accepted and the pop is ignored (`rx_valid` was 0).
  - Pointers wrap modulo FIFO_DEPTH.
- `frame_err` and `overrun` never assert in the same cycle. A framing error performs no push.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, `fifo_count`=0, FSM=IDLE, synchronizer=1.
- Reset asserted mid-frame aborts the frame and empties the FIFO. No flags pulse.
- Latency: a line edge reaches `rx_s` after 2 `clk` edges.
- Sample points: the start-bit sample is `HALF_CYCLES` cycles after the detect. Each later sample is `BIT_CYCLES` cycles after the previous one.
- Output timing: `rx_valid` (for an empty FIFO) or the `overrun`/`frame_err` pulse rises on the clock edge after the stop-bit sample cycle.
- `fifo_count` updates on the same edge as the push or pop.
- `busy` rises the cycle after start detection and falls on entering IDLE.
- Baud tolerance: ±2% cumulative at 9 samples.

## Test plan
- Single byte, defaults: drive 0x48 at 8680 ns/bit with `rx_ready`=1.
  - Required: `rx_valid` pulses with `rx_data`=0x48.
  - `fifo_count` goes 0→1→0; `frame_err`=0 and `overrun`=0 throughout.
- Stream: send "Hello World!\n" (0x48 65 6C 6C 6F 20 57 6F 72 6C 64 21 0A) back-to-back with one stop bit.
  - Required: 13 pops in order, no flags.
- Glitch: drive `rx_in` low for 100 cycles (< `HALF_CYCLES`), then high.
  - Required: `busy` high for ~`HALF_CYCLES` then 0; no push; no flags.
- Framing error: send 0x55 with stop bit = 0, hold low 2000 cycles, release high, then send 0xA5.
  - Required: exactly one `frame_err` pulse and no push for 0x55.
  - FSM stays in BREAK while low.
  - 0xA5 is received correctly.
- Overrun: `rx_ready`=0, send 0x01–0x05.
  - Required: `fifo_count`=4 and one `overrun` pulse after the 5th byte.
  - Then `rx_ready`=1 pops exactly 0x01, 0x02, 0x03, 0x04.
- Reset mid-frame: with 2 bytes queued, pulse `rst` during bit 3 of a third byte.
  - Required: all outputs return to reset values immediately.
  - The next full frame 0x3C is received as the only byte.
